// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_unit_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_EXC,
    SEL_HOLD
  } next_sel_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;

  // Low 28 bits of a J/JAL target; the caller supplies the upper pc_plus4 bits.
  function automatic logic [27:0] jump_target(input logic [25:0] index);
    return {index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Debug trace-reader port of the program-counter unit.
interface pc_unit_if #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned TRACE_DEPTH = 16
);
  localparam int unsigned LW = $clog2(TRACE_DEPTH) + 1;

  logic            trace_rd;
  logic            trace_clear;
  logic [PC_W-1:0] trace_data;
  logic            trace_valid;
  logic [LW-1:0]   trace_level;
  logic            trace_overflow;

  modport master (
    output trace_rd, trace_clear,
    input  trace_data, trace_valid, trace_level, trace_overflow
  );

  modport slave (
    input  trace_rd, trace_clear,
    output trace_data, trace_valid, trace_level, trace_overflow
  );
endinterface

// File: rtl/pc_trace_buf.sv
// Overwrite-oldest circular buffer with push/pop/clear, level and sticky overflow.
module pc_trace_buf #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic [W-1:0]               data,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head, tail, head_n, tail_n;
  logic [LW-1:0] count_n;
  logic          ovf_n, wr, full, pop_ok;

  assign full   = (level == LW'(DEPTH));
  assign pop_ok = pop && valid;
  assign data   = mem[head];

  // Next pointer/count/overflow; clear wins over any push or pop this cycle.
  always_comb begin
    head_n  = head;
    tail_n  = tail;
    count_n = level;
    ovf_n   = overflow;
    wr      = 1'b0;
    if (clear) begin
      head_n  = '0;
      tail_n  = '0;
      count_n = '0;
      ovf_n   = 1'b0;
    end else begin
      if (push) begin
        wr     = 1'b1;
        tail_n = tail + AW'(1);
      end
      if (push && pop_ok) begin
        head_n = head + AW'(1);
      end else if (push && full) begin
        head_n = head + AW'(1);
        ovf_n  = 1'b1;
      end else if (push) begin
        count_n = level + LW'(1);
      end else if (pop_ok) begin
        head_n  = head + AW'(1);
        count_n = level - LW'(1);
      end
    end
  end

  // Pointer and status registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      level    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      head     <= head_n;
      tail     <= tail_n;
      level    <= count_n;
      valid    <= (count_n != '0);
      overflow <= ovf_n;
    end
  end

  // Entry storage; contents need no reset since level gates visibility.
  always_ff @(posedge clock) begin
    if (wr) mem[tail] <= push_data;
  end
endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC selection, EPC capture, retire counter and trace buffer.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned     PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_VEC   = PC_W'(DEF_RESET_VEC),
  parameter logic [PC_W-1:0] EXC_VEC     = PC_W'(DEF_EXC_VEC),
  parameter int unsigned     TRACE_DEPTH = 16,
  parameter int unsigned     CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             jump_reg,
  input  logic [PC_W-1:0]  reg_target,
  input  logic             exception,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus4,
  output logic [PC_W-1:0]  epc,
  output logic             misaligned,
  output logic [CNT_W-1:0] retire_count,
  pc_unit_if.slave         dbg
);
  next_sel_e       sel;
  logic [PC_W-1:0] next_pc;
  logic            misalign_take, update;

  assign pc_plus4 = pc + PC_W'(4);
  assign update   = (sel != SEL_HOLD);

  // Next-PC priority: exception, stall, jump_reg (misaligned -> exception), jump, branch, sequential.
  always_comb begin
    sel           = SEL_SEQ;
    misalign_take = 1'b0;
    if (exception) begin
      sel = SEL_EXC;
    end else if (stall) begin
      sel = SEL_HOLD;
    end else if (jump_reg) begin
      if (reg_target[1:0] != 2'b00) begin
        sel           = SEL_EXC;
        misalign_take = 1'b1;
      end else begin
        sel = SEL_JR;
      end
    end else if (jump) begin
      sel = SEL_J;
    end else if (branch_taken) begin
      sel = SEL_BR;
    end
  end

  // Target mux for the selected source.
  always_comb begin
    next_pc = pc_plus4;
    unique case (sel)
      SEL_EXC:  next_pc = EXC_VEC;
      SEL_HOLD: next_pc = pc;
      SEL_JR:   next_pc = reg_target;
      SEL_J:    next_pc = {pc_plus4[PC_W-1:28], jump_target(jump_index)};
      SEL_BR:   next_pc = pc_plus4 + (branch_offset << 2);
      default:  next_pc = pc_plus4;
    endcase
  end

  // PC, EPC, sticky misaligned flag and retire counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc           <= RESET_VEC;
      epc          <= '0;
      misaligned   <= 1'b0;
      retire_count <= '0;
    end else begin
      if (update) begin
        pc           <= next_pc;
        retire_count <= retire_count + CNT_W'(1);
      end
      if (sel == SEL_EXC) epc <= pc;
      if (dbg.trace_clear)    misaligned <= 1'b0;
      else if (misalign_take) misaligned <= 1'b1;
    end
  end

  pc_trace_buf #(
    .W     (PC_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clock     (clock),
    .reset     (reset),
    .push      (update),
    .push_data (next_pc),
    .pop       (dbg.trace_rd),
    .clear     (dbg.trace_clear),
    .data      (dbg.trace_data),
    .valid     (dbg.trace_valid),
    .level     (dbg.trace_level),
    .overflow  (dbg.trace_overflow)
  );
endmodule

// File: tb/tb_pc_unit.sv
// Directed vector bench for pc_unit.
module tb_pc_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall, branch_taken, jump, jump_reg, exception;
  logic [31:0] branch_offset, reg_target;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus4, epc, retire_count;
  logic        misaligned;

  pc_unit_if #(.PC_W(32), .TRACE_DEPTH(16)) dbg ();

  pc_unit #(
    .PC_W        (32),
    .RESET_VEC   (32'h0000_0000),
    .EXC_VEC     (32'h0000_0080),
    .TRACE_DEPTH (16),
    .CNT_W       (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .reg_target    (reg_target),
    .exception     (exception),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .epc           (epc),
    .misaligned    (misaligned),
    .retire_count  (retire_count),
    .dbg           (dbg)
  );

  always #5 clock = ~clock;

  // control bit masks: {stall, branch, jump, jump_reg, exception, trace_rd, trace_clear}
  localparam logic [6:0] S = 7'd64, B = 7'd32, J = 7'd16, R = 7'd8, E = 7'd4, RD = 7'd2, CL = 7'd1;

  typedef struct {
    logic [6:0]  c;
    logic [31:0] arg;
    logic [31:0] e_pc, e_epc;
    logic        e_mis;
    logic [31:0] e_rc;
    logic [4:0]  e_lvl;
    logic        e_ovf;
    logic [31:0] e_td;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vt[26];

  function automatic vec_t mk(logic [6:0] c, logic [31:0] arg, logic [31:0] e_pc,
                              logic [31:0] e_epc, logic e_mis, int e_rc, int e_lvl,
                              logic e_ovf, logic [31:0] e_td);
    vec_t v;
    v.c = c; v.arg = arg; v.e_pc = e_pc; v.e_epc = e_epc; v.e_mis = e_mis;
    v.e_rc = 32'(e_rc); v.e_lvl = 5'(e_lvl); v.e_ovf = e_ovf; v.e_td = e_td;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] c, input logic [31:0] arg);
    stall           = c[6];
    branch_taken    = c[5];
    jump            = c[4];
    jump_reg        = c[3];
    exception       = c[2];
    dbg.trace_rd    = c[1];
    dbg.trace_clear = c[0];
    branch_offset   = arg;
    jump_index      = arg[25:0];
    reg_target      = arg;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_rc,
                           input int e_lvl, input logic e_ovf);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
    chk({tag, ".retire"}, retire_count, e_rc);
    chk({tag, ".level"}, 32'(dbg.trace_level), 32'(e_lvl));
    chk({tag, ".valid"}, 32'(dbg.trace_valid), 32'(e_lvl != 0));
    chk({tag, ".overflow"}, 32'(dbg.trace_overflow), 32'(e_ovf));
  endtask

  initial begin
    logic [31:0] exp_pc, exp_rc;
    logic [31:0] pushed[20];

    vt[0]  = mk(0,       32'h0,        32'h4,        0,       0, 1,  1,  0, 32'h4);
    vt[1]  = mk(0,       32'h0,        32'h8,        0,       0, 2,  2,  0, 32'h4);
    vt[2]  = mk(0,       32'h0,        32'hC,        0,       0, 3,  3,  0, 32'h4);
    vt[3]  = mk(0,       32'h0,        32'h10,       0,       0, 4,  4,  0, 32'h4);
    vt[4]  = mk(B,       32'hFFFFFFFE, 32'hC,        0,       0, 5,  5,  0, 32'h4);
    vt[5]  = mk(J,       32'h40,       32'h100,      0,       0, 6,  6,  0, 32'h4);
    vt[6]  = mk(J,       32'h8,        32'h20,       0,       0, 7,  7,  0, 32'h4);
    vt[7]  = mk(S,       32'h0,        32'h20,       0,       0, 7,  7,  0, 32'h4);
    vt[8]  = mk(S,       32'h0,        32'h20,       0,       0, 7,  7,  0, 32'h4);
    vt[9]  = mk(S,       32'h0,        32'h20,       0,       0, 7,  7,  0, 32'h4);
    vt[10] = mk(S|E,     32'h0,        32'h80,       32'h20,  0, 8,  8,  0, 32'h4);
    vt[11] = mk(J,       32'h10,       32'h40,       32'h20,  0, 9,  9,  0, 32'h4);
    vt[12] = mk(R,       32'h202,      32'h80,       32'h40,  1, 10, 10, 0, 32'h4);
    vt[13] = mk(CL,      32'h0,        32'h84,       32'h40,  0, 11, 0,  0, 32'h0);
    vt[14] = mk(0,       32'h0,        32'h88,       32'h40,  0, 12, 1,  0, 32'h88);
    vt[15] = mk(RD,      32'h0,        32'h8C,       32'h40,  0, 13, 1,  0, 32'h8C);
    vt[16] = mk(S|RD,    32'h0,        32'h8C,       32'h40,  0, 13, 0,  0, 32'h0);
    vt[17] = mk(S|RD,    32'h0,        32'h8C,       32'h40,  0, 13, 0,  0, 32'h0);
    vt[18] = mk(R,       32'h1000,     32'h1000,     32'h40,  0, 14, 1,  0, 32'h1000);
    vt[19] = mk(B,       32'h3,        32'h1010,     32'h40,  0, 15, 2,  0, 32'h1000);
    vt[20] = mk(R|J|B,   32'h200,      32'h200,      32'h40,  0, 16, 3,  0, 32'h1000);
    vt[21] = mk(J|B,     32'h3,        32'hC,        32'h40,  0, 17, 4,  0, 32'h1000);
    vt[22] = mk(R,       32'hFFFFFFFC, 32'hFFFFFFFC, 32'h40,  0, 18, 5,  0, 32'h1000);
    vt[23] = mk(0,       32'h0,        32'h0,        32'h40,  0, 19, 6,  0, 32'h1000);
    vt[24] = mk(R,       32'h30000000, 32'h30000000, 32'h40,  0, 20, 7,  0, 32'h1000);
    vt[25] = mk(J,       32'h1,        32'h30000004, 32'h40,  0, 21, 8,  0, 32'h1000);

    drive(0, 0);
    #12;
    chk_state("reset", 32'h0, 32'h0, 0, 1'b0);
    chk("reset.epc", epc, 32'h0);
    chk("reset.mis", 32'(misaligned), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    for (int unsigned i = 0; i < 26; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(vt[i].c, vt[i].arg);
      tick();
      chk_state(tag, vt[i].e_pc, vt[i].e_rc, int'(vt[i].e_lvl), vt[i].e_ovf);
      chk({tag, ".epc"}, epc, vt[i].e_epc);
      chk({tag, ".mis"}, 32'(misaligned), 32'(vt[i].e_mis));
      if (vt[i].e_lvl != 0) chk({tag, ".tdata"}, dbg.trace_data, vt[i].e_td);
    end

    // Overflow: 20 pushes into 16 entries drop the oldest four.
    exp_pc = 32'h30000008;
    exp_rc = 32'd22;
    drive(CL, 0);
    tick();
    chk_state("ovf.clr", exp_pc, exp_rc, 0, 1'b0);
    drive(0, 0);
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_pc += 32'd4;
      exp_rc += 32'd1;
      pushed[k] = exp_pc;
    end
    chk_state("ovf.full", exp_pc, exp_rc, 16, 1'b1);
    chk("ovf.tdata", dbg.trace_data, pushed[4]);
    drive(RD, 0);
    tick();
    exp_pc += 32'd4;
    exp_rc += 32'd1;
    chk_state("ovf.poppush", exp_pc, exp_rc, 16, 1'b1);
    chk("ovf.poppush.tdata", dbg.trace_data, pushed[5]);

    // Exactly full, then pop+push: no overflow must appear.
    drive(CL, 0);
    tick();
    exp_pc += 32'd4;
    exp_rc += 32'd1;
    chk_state("full.clr", exp_pc, exp_rc, 0, 1'b0);
    drive(0, 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_pc += 32'd4;
      exp_rc += 32'd1;
      pushed[k] = exp_pc;
    end
    chk_state("full.16", exp_pc, exp_rc, 16, 1'b0);
    chk("full.16.tdata", dbg.trace_data, pushed[0]);
    drive(RD, 0);
    tick();
    exp_pc += 32'd4;
    exp_rc += 32'd1;
    chk_state("full.poppush", exp_pc, exp_rc, 16, 1'b0);
    chk("full.poppush.tdata", dbg.trace_data, pushed[1]);

    // Asynchronous reset mid-stream with level 7 at pc 0x3C.
    drive(R | CL, 32'h20);
    tick();
    exp_rc += 32'd1;
    chk_state("rst.pre0", 32'h20, exp_rc, 0, 1'b0);
    drive(0, 0);
    for (int k = 0; k < 7; k++) tick();
    exp_rc += 32'd7;
    chk_state("rst.pre", 32'h3C, exp_rc, 7, 1'b0);
    reset = 1'b0;
    #1;
    chk_state("rst.async", 32'h0, 32'h0, 0, 1'b0);
    chk("rst.async.epc", epc, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk_state("rst.after", 32'h4, 32'h1, 1, 1'b0);
    chk("rst.after.tdata", dbg.trace_data, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the MIPS cores. It replaces the plain PC register with on-chip next-PC selection:
- sequential, branch, jump, jump-register, exception vector
- stall hold
- misaligned-target detection with EPC capture
- retire counter
- circular trace buffer of committed PC values, drained by a debug reader in place of simulation file dumps

It sits between the control unit/ALU branch logic and instruction memory.

Parameters:
PC_W, 32, PC width in bits; must be >= 32 for jump concatenation.
RESET_VEC, 32'h0000_0000, PC value loaded on reset.
EXC_VEC, 32'h0000_0080, PC value loaded on exception.
TRACE_DEPTH, 16, trace buffer entries; power of two, >= 2.
CNT_W, 32, retire counter width.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
stall  in  1  hold PC (ignored when an exception is taken)
branch_taken  in  1  take branch
branch_offset  in  PC_W  sign-extended word offset (target = pc_plus4 + (offset<<2))
jump  in  1  J/JAL
jump_index  in  26  instruction index field
jump_reg  in  1  JR/JALR
reg_target  in  PC_W  register target for jump_reg
exception  in  1  external exception request
pc  out  PC_W  current PC
pc_plus4  out  PC_W  pc + 4 (combinational)
epc  out  PC_W  exception PC
misaligned  out  1  sticky: misaligned target detected
retire_count  out  CNT_W  committed PC updates
trace_rd  in  1  pop request
trace_data  out  PC_W  oldest trace entry (combinational from head)
trace_valid  out  1  buffer not empty
trace_level  out  $clog2(TRACE_DEPTH)+1  entries held
trace_overflow  out  1  sticky: entry overwritten
trace_clear  in  1  empty buffer, clear overflow and misaligned

Behaviour:
- Reset (async, reset=0): pc=RESET_VEC, epc=0, misaligned=0, retire_count=0, trace empty (level 0, valid 0), trace_overflow=0. Reset mid-operation discards all state immediately.
- Next-PC priority, evaluated each rising edge:
  1. exception
  2. stall (hold)
  3. jump_reg
  4. jump
  5. branch_taken
  6. pc_plus4
- jump target = {pc_plus4[PC_W-1:28], jump_index, 2'b00}.
- branch target = pc_plus4 + (branch_offset << 2), mod 2^PC_W.
- Sequential wrap-around at max address is modular; no flag.
- Misaligned target: selected jump_reg target with reg_target[1:0] != 0 is treated as an exception:
  - pc <= EXC_VEC, epc <= pc, misaligned <= 1.
- exception=1: pc <= EXC_VEC, epc <= pc. Overrides stall.
- Update = any edge where pc is loaded (not held by stall). On each update:
  - retire_count += 1, wraps at 2^CNT_W.
  - The newly loaded PC value is pushed to the trace buffer. Latency: visible on trace_data next cycle if the buffer was empty.
- Trace buffer: circular, head/tail pointers plus count.
  - Push when full: oldest entry dropped (head advances), trace_overflow <= 1, level stays TRACE_DEPTH.
  - trace_rd with trace_valid=0: ignored.
  - Push and pop in the same cycle: level unchanged. When full, this does not set overflow.
  - trace_clear: level <= 0, overflow <= 0, misaligned <= 0. It has priority over push/pop that cycle; the push is discarded, but the PC update still occurs.
- All outputs except pc_plus4 and trace_data are registered.

Decomposition:
- Package pc_unit_pkg:
  - next-PC select enum: SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_EXC, SEL_HOLD
  - default RESET_VEC and EXC_VEC constants
  - function jump_target()
- One natural sub-module, pc_trace_buf: parametrised overwrite-oldest circular buffer with push/pop/clear, level and overflow.

Test Plan:
- Reset release with no controls: pc 0,4,8,12; retire_count=3 after 3 edges; trace_data=4, level=3.
- branch_taken with offset=-2 at pc=0x10 -> pc=0x0C. Then jump with index=0x40 at pc=0x0C -> pc=0x100.
- stall=1 for 3 cycles at pc=0x20 -> pc held at 0x20, retire_count unchanged, no pushes. exception during stall -> pc=0x80, epc=0x20.
- jump_reg with reg_target=0x202 at pc=0x40 -> pc=0x80, epc=0x40, misaligned=1. trace_clear -> misaligned=0, level=0.
- 20 updates, TRACE_DEPTH=16, no reads -> level=16, overflow=1, trace_data=5th pushed value. Pop+push when full -> level=16, only the pre-existing overflow remains.
- Assert reset mid-stream with level=7, pc=0x3C -> pc=0 immediately (asynchronous), level=0, counters 0.
